ex_stage: RTL

//  Execute stage of the 5-stage RV32I pipeline: ID/EX operands through forwarding muxes and ALU.

---
 rtl/ex_pkg.sv | 31 +++
 rtl/alu_unit.sv | 29 ++
 rtl/ex_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the RV32I execute stage
package ex_pkg;
   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
   } alu_ctrl_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // x0 is hard-wired to zero, so a write to it never forwards
   function automatic logic fwd_hit(input logic we, input logic [RADDR_W-1:0] rd, input logic [RADDR_W-1:0] rs);
      return we && rd != '0 && rd == rs;
   endfunction
endpackage

// File: rtl/alu_unit.sv
// alu_unit: combinational RV32I integer ALU with zero flag
module alu_unit
   import ex_pkg::*;
(
   input  alu_ctrl_e       ctrl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $signed(a) >>> b[4:0];
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = a + b;
      endcase
   end

   assign zero = ~|result;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with operand forwarding, ALU and EX/MEM pipeline register
module ex_stage
   import ex_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold_EX,
   input  logic               flush_EX,
   input  logic [XLEN-1:0]    pc_IDEX,
   input  logic [XLEN-1:0]    rs1_data_IDEX,
   input  logic [XLEN-1:0]    rs2_data_IDEX,
   input  logic [XLEN-1:0]    imm_IDEX,
   input  logic [RADDR_W-1:0] rs1_IDEX,
   input  logic [RADDR_W-1:0] rs2_IDEX,
   input  logic [RADDR_W-1:0] rd_IDEX,
   input  logic               aluSrc_IDEX,
   input  logic [1:0]         aluOp_IDEX,
   input  logic [2:0]         funct3_IDEX,
   input  logic               funct7b5_IDEX,
   input  logic               branch_IDEX,
   input  logic               memRead_IDEX,
   input  logic               memWrite_IDEX,
   input  logic               mem2reg_IDEX,
   input  logic               RegWrite_IDEX,
   input  logic [RADDR_W-1:0] rd_MEMWB,
   input  logic               RegWrite_MEMWB,
   input  logic [XLEN-1:0]    wb_data_MEMWB,
   output logic [XLEN-1:0]    read_Address_EXMEM,
   output logic [XLEN-1:0]    write_Data_EXMEM,
   output logic [XLEN-1:0]    branch_target_EXMEM,
   output logic [RADDR_W-1:0] rd_EXMEM,
   output logic               zero_EXMEM,
   output logic               branch_EXMEM,
   output logic               memRead_EXMEM,
   output logic               memWrite_EXMEM,
   output logic               mem2reg_EXMEM,
   output logic               RegWrite_EXMEM
);
   alu_ctrl_e       ctrl;
   logic [XLEN-1:0] op_a, fwd_b, op_b, result;
   logic            zero;

   // EX/MEM wins over MEM/WB: it holds the younger write to the same register
   assign op_a  = fwd_hit(RegWrite_EXMEM, rd_EXMEM, rs1_IDEX) ? read_Address_EXMEM :
                  fwd_hit(RegWrite_MEMWB, rd_MEMWB, rs1_IDEX) ? wb_data_MEMWB : rs1_data_IDEX;
   assign fwd_b = fwd_hit(RegWrite_EXMEM, rd_EXMEM, rs2_IDEX) ? read_Address_EXMEM :
                  fwd_hit(RegWrite_MEMWB, rd_MEMWB, rs2_IDEX) ? wb_data_MEMWB : rs2_data_IDEX;
   assign op_b  = aluSrc_IDEX ? imm_IDEX : fwd_b;

   always_comb begin
      ctrl = ALU_ADD;
      if (aluOp_IDEX == ALUOP_SUB)
         ctrl = ALU_SUB;
      else if (aluOp_IDEX == ALUOP_FUNCT)
         case (funct3_IDEX)
            F3_ADD:  ctrl = funct7b5_IDEX && !aluSrc_IDEX ? ALU_SUB : ALU_ADD;
            F3_SLL:  ctrl = ALU_SLL;
            F3_SLT:  ctrl = ALU_SLT;
            F3_SLTU: ctrl = ALU_SLTU;
            F3_XOR:  ctrl = ALU_XOR;
            F3_SR:   ctrl = funct7b5_IDEX ? ALU_SRA : ALU_SRL;
            F3_OR:   ctrl = ALU_OR;
            default: ctrl = ALU_AND;
         endcase
   end

   alu_unit u_alu (
      .ctrl   (ctrl),
      .a      (op_a),
      .b      (op_b),
      .result (result),
      .zero   (zero)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         read_Address_EXMEM  <= '0;
         write_Data_EXMEM    <= '0;
         branch_target_EXMEM <= '0;
         rd_EXMEM            <= '0;
         zero_EXMEM          <= 1'b0;
         {branch_EXMEM, memRead_EXMEM, memWrite_EXMEM, mem2reg_EXMEM, RegWrite_EXMEM} <= 5'b0;
      end else if (flush_EX || !hold_EX) begin
         read_Address_EXMEM  <= result;
         write_Data_EXMEM    <= fwd_b;
         branch_target_EXMEM <= pc_IDEX + imm_IDEX;
         rd_EXMEM            <= rd_IDEX;
         zero_EXMEM          <= zero;
         {branch_EXMEM, memRead_EXMEM, memWrite_EXMEM, mem2reg_EXMEM, RegWrite_EXMEM} <= flush_EX ? 5'b0 :
            {branch_IDEX, memRead_IDEX, memWrite_IDEX, mem2reg_IDEX, RegWrite_IDEX};
      end
endmodule
